// File: rtl/mem_dma_engine.sv
// Block-copy DMA engine on a single-port word memory: two cycles per word (read, then write).
// Optional constant-fill mode (one cycle per word) is built when MEM_DMA_FILL_EN is defined.
module mem_dma_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef MEM_DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

`ifdef MEM_DMA_FILL_EN
  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StFill} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  // Byte-address bit 0 is ignored on the word-aligned pointers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = src_addr[0] ^ dst_addr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = {src_addr[ADDR_W-1:1], 1'b0};
          dst_d   = {dst_addr[ADDR_W-1:1], 1'b0};
          count_d = len;
          if (len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
`ifdef MEM_DMA_FILL_EN
            if (fill_mode) begin
              buf_d   = fill_value;
              state_d = StFill;
            end
`endif
          end
        end
      end
      StRead: begin
        buf_d   = mem_read_data;
        state_d = StWrite;
      end
      StWrite: begin
        src_d   = src_q + ADDR_W'(2);
        dst_d   = dst_q + ADDR_W'(2);
        count_d = count_q - LEN_W'(1);
        state_d = (count_q == LEN_W'(1)) ? StDone : StRead;
      end
`ifdef MEM_DMA_FILL_EN
      StFill: begin
        dst_d   = dst_q + ADDR_W'(2);
        count_d = count_q - LEN_W'(1);
        if (count_q == LEN_W'(1)) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend on registered state only, so start never reaches the memory port directly.
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state_q)
      StRead: begin
        busy            = 1'b1;
        mem_read        = 1'b1;
        mem_access_addr = src_q;
      end
      StWrite: begin
        busy            = 1'b1;
        mem_write_en    = 1'b1;
        mem_access_addr = dst_q;
        mem_write_data  = buf_q;
      end
`ifdef MEM_DMA_FILL_EN
      StFill: begin
        busy            = 1'b1;
        mem_write_en    = 1'b1;
        mem_access_addr = dst_q;
        mem_write_data  = buf_q;
      end
`endif
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Scoreboard bench for mem_dma_engine: a behavioural memory plus a reference copy model.
// Define MEM_DMA_FILL_EN to also exercise the fill path.
module tb_mem_dma_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        fill_mode;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  mem_dma_engine #(
    .ADDR_W(16),
    .DATA_W(16),
    .LEN_W (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
`ifdef MEM_DMA_FILL_EN
    .fill_mode      (fill_mode),
    .fill_value     (fill_value),
`endif
    .busy           (busy),
    .done           (done),
    .mem_access_addr(mem_access_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] mem     [0:32767];
  bit          written [0:32767];
  logic [15:0] ref_mem [0:32767];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_done   = 0;
  int          n_reads  = 0;

  function automatic logic [15:0] init_word(input logic [14:0] idx);
    logic [15:0] a;
    a = {idx, 1'b0};
    if (a >= 16'h0010 && a <= 16'h0016) return 16'hA001 + 16'(idx - 15'd8);
    return a ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] rd_word(input logic [14:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  always_comb begin
    mem_read_data = 16'h0;
    if (mem_read) mem_read_data = rd_word(mem_access_addr[15:1]);
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_access_addr[15:1]]     <= mem_write_data;
      written[mem_access_addr[15:1]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Monitor: every observed write must match the next scoreboard entry.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (done) n_done++;
      if (mem_read) n_reads++;
      if (mem_read && mem_write_en) check("rd_wr_overlap", 32'd1, 32'd0);
      if (mem_write_en) begin
        if (sb.size() == 0) begin
          check("unexpected_wr", {mem_access_addr, mem_write_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", {16'h0, mem_access_addr}, {16'h0, e.a});
          check("wr_data", {16'h0, mem_write_data}, {16'h0, e.d});
        end
      end
    end
  end

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (rd_word(15'(i)) !== ref_mem[i]) diffs++;
    for (int i = 32752; i < 32768; i++) if (rd_word(15'(i)) !== ref_mem[i]) diffs++;
    check(tag, 32'(diffs), 32'd0);
  endtask

  task automatic model(input logic [15:0] s, input logic [15:0] d, input int n,
                       input logic fm, input logic [15:0] fv);
    logic [15:0] sa, da, v;
    sa = {s[15:1], 1'b0};
    da = {d[15:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      v = fm ? fv : ref_mem[sa[15:1]];
      ref_mem[da[15:1]] = v;
      sb.push_back('{a: da, d: v});
      sa = sa + 16'd2;
      da = da + 16'd2;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input int n, input logic fm, input logic [15:0] fv,
                          input bit inject);
    int k;
    int exp_k;
    int done0;
    done0 = n_done;
    exp_k = (n == 0) ? 1 : (fm ? n + 1 : 2 * n + 1);
    model(s, d, n, fm, fv);
    @(negedge clk);
    start      = 1'b1;
    src_addr   = s;
    dst_addr   = d;
    len        = 8'(n);
    fill_mode  = fm;
    fill_value = fv;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    if (n > 0) check({tag, "_busy"}, {31'h0, busy}, 32'd1);
    while (!done && k < 600) begin
      if (inject && k == 3) begin
        start    = 1'b1;
        dst_addr = 16'h0080;
        len      = 8'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
    check({tag, "_busy_at_done"}, {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_count"}, 32'(n_done - done0), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int reads0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));
    rst_n      = 1'b0;
    start      = 1'b1;
    src_addr   = 16'h0010;
    dst_addr   = 16'h0040;
    len        = 8'd4;
    fill_mode  = 1'b0;
    fill_value = 16'h0;

    // Reset held with start asserted: outputs stay quiet.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_outs", {busy, done, mem_write_en, mem_read, mem_access_addr, mem_write_data},
            32'd0);
    end
    check_mem("rst_mem");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", {30'h0, busy, done}, 32'd0);

    run_xfer("basic", 16'h0010, 16'h0040, 4, 1'b0, 16'h0, 1'b0);
    run_xfer("len0", 16'h0010, 16'h0040, 0, 1'b0, 16'h0, 1'b0);
    run_xfer("ignore_start", 16'h0010, 16'h0040, 4, 1'b0, 16'h0, 1'b1);
    run_xfer("odd_addr", 16'h0011, 16'h00A1, 3, 1'b0, 16'h0, 1'b0);
    run_xfer("overlap", 16'h0010, 16'h0012, 3, 1'b0, 16'h0, 1'b0);
    run_xfer("wrap_src", 16'hFFFC, 16'h0100, 3, 1'b0, 16'h0, 1'b0);

    // Reset during the write of word 2: only word 1 lands.
    model(16'h0010, 16'h0060, 1, 1'b0, 16'h0);
    @(negedge clk);
    start    = 1'b1;
    src_addr = 16'h0010;
    dst_addr = 16'h0060;
    len      = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midrst_wr2_active", {31'h0, mem_write_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {busy, done, mem_write_en, mem_read, mem_access_addr, mem_write_data},
          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sb", 32'(sb.size()), 32'd0);
    check_mem("midrst_mem");
    run_xfer("after_rst", 16'h0010, 16'h0060, 4, 1'b0, 16'h0, 1'b0);

`ifdef MEM_DMA_FILL_EN
    reads0 = n_reads;
    run_xfer("fill_wrap", 16'h1234, 16'hFFFC, 3, 1'b1, 16'h5A5A, 1'b0);
    check("fill_no_reads", 32'(n_reads - reads0), 32'd0);
`else
    reads0 = n_reads;
    run_xfer("copy_last", 16'h0040, 16'h00C0, 2, 1'b0, 16'h0, 1'b0);
    check("copy_reads", 32'(n_reads - reads0), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
